// File: rtl/dac_pkg.sv
// Shared constants, frame commands, FSM state type and input clamp for the SPI DAC writer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dac_pkg;

  localparam int FRAME_W  = 16;
  localparam int CODE_W   = 12;
  localparam int CODE_MAX = 4095;

  // Command nibble: write-and-update, or write input register only (LDAC updates)
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_WRITE_INPUT  = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CS_HOLD
  } state_t;

  // Saturate the signed regulator output into the 12-bit DAC code range
  function automatic logic [CODE_W-1:0] clamp_code(input logic signed [31:0] v);
    if (v < 0)
      return '0;
    else if (v > CODE_MAX)
      return CODE_W'(CODE_MAX);
    else
      return v[CODE_W-1:0];
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV cycles after start, flags the edge being made.
// Latency: first rise CLK_DIV cycles after the start edge; ticks are same-cycle flags.
// Backpressure: none; clear stops the clock and returns sclk low immediately at the edge.
module dac_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  output logic       sclk,
  output logic       rise_tick,
  output logic       fall_tick,
  output logic [4:0] edge_cnt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          running;
  logic          half_tick;

  // The current edge ends a half-period; the tick names the sclk edge it produces
  assign half_tick = running && (div_cnt == DW'(CLK_DIV - 1));
  assign rise_tick = half_tick && !sclk;
  assign fall_tick = half_tick && sclk;

  // Divider, sclk toggle and count of sclk edges made since start (32 per frame)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      running  <= 1'b0;
      div_cnt  <= '0;
      sclk     <= 1'b0;
      edge_cnt <= '0;
    end else if (clear) begin
      running  <= 1'b0;
      div_cnt  <= '0;
      sclk     <= 1'b0;
      edge_cnt <= '0;
    end else if (start) begin
      running  <= 1'b1;
      div_cnt  <= '0;
      sclk     <= 1'b0;
      edge_cnt <= '0;
    end else if (running) begin
      if (half_tick) begin
        div_cnt  <= '0;
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 5'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/dac_spi_writer.sv
// SPI DAC writer: clamps each strobed sample to 12 bits, sends {CMD,code} MSB-first; DAC_LDAC_EN adds an LDAC pulse.
// Latency: CS low 2 cycles after capture, done 33*CLK_DIV+1 cycles after capture (34*CLK_DIV+1 with LDAC).
// Backpressure: none; one-deep pending slot, newest sample overwrites an unsent one and pulses overrun.
module dac_spi_writer
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [31:0] PIDout,
  output logic               dac_cs_n,
  output logic               dac_sclk,
  output logic               dac_mosi,
  output logic               busy,
  output logic               done,
  output logic               overrun
`ifdef DAC_LDAC_EN
  ,
  output logic               dac_ldac_n
`endif
);

`ifdef DAC_LDAC_EN
  localparam logic [3:0] CMD      = CMD_WRITE_INPUT;
  localparam int         HOLD_CYC = 2 * CLK_DIV;
`else
  localparam logic [3:0] CMD      = CMD_WRITE_UPDATE;
  localparam int         HOLD_CYC = CLK_DIV;
`endif
  localparam int HW = $clog2(HOLD_CYC);

  state_t              state;
  logic [CODE_W-1:0]   pend_code;
  logic                pend_valid;
  logic [FRAME_W-1:0]  shreg;
  logic [FRAME_W-1:0]  frame;
  logic [HW-1:0]       hold_cnt;
  logic                rise_tick;
  logic                fall_tick;
  logic [4:0]          edge_cnt;
  logic                last_fall;
  logic                sclk_start;
  logic                sclk_clear;

  assign frame      = {CMD, pend_code};
  assign last_fall  = fall_tick && (edge_cnt == 5'd31);
  assign sclk_start = (state == ST_LOAD);
  assign sclk_clear = (state == ST_SHIFT) && last_fall;

  dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clock     (clock),
    .reset     (reset),
    .start     (sclk_start),
    .clear     (sclk_clear),
    .sclk      (dac_sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .edge_cnt  (edge_cnt)
  );

  // Pending slot: strobe always wins over the LOAD-cycle clear; overwrite outside LOAD flags overrun
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_code  <= '0;
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= enable && pend_valid && (state != ST_LOAD);
      if (enable) begin
        pend_code  <= clamp_code(PIDout);
        pend_valid <= 1'b1;
      end else if (state == ST_LOAD) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Frame sequencer with registered pin outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      dac_cs_n   <= 1'b1;
      dac_mosi   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      shreg      <= '0;
      hold_cnt   <= '0;
`ifdef DAC_LDAC_EN
      dac_ldac_n <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pend_valid) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          shreg    <= frame;
          dac_mosi <= frame[FRAME_W-1];
          dac_cs_n <= 1'b0;
          state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Advance after the DAC has sampled on the rise; present the next bit on the fall
          if (rise_tick)
            shreg <= {shreg[FRAME_W-2:0], 1'b0};
          if (fall_tick) begin
            if (last_fall) begin
              dac_cs_n   <= 1'b1;
              dac_mosi   <= 1'b0;
              hold_cnt   <= '0;
              state      <= ST_CS_HOLD;
`ifdef DAC_LDAC_EN
              dac_ldac_n <= 1'b0;
`endif
            end else begin
              dac_mosi <= shreg[FRAME_W-1];
            end
          end
        end
        ST_CS_HOLD: begin
          hold_cnt <= hold_cnt + HW'(1);
`ifdef DAC_LDAC_EN
          if (hold_cnt == HW'(CLK_DIV - 1))
            dac_ldac_n <= 1'b1;
`endif
          if (hold_cnt == HW'(HOLD_CYC - 2))
            done <= 1'b1;
          if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Directed bench for dac_spi_writer: frame contents, timeline, clamping, overrun and async reset.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_dac_spi_writer;

  localparam int D = 4;
`ifdef DAC_LDAC_EN
  localparam int         HOLD    = 2 * D;
  localparam logic [3:0] CMD     = 4'b0000;
  localparam int         SINGLE  = 100;
  localparam logic [15:0] SINGLE_FRAME = 16'h0064;
`else
  localparam int         HOLD    = D;
  localparam logic [3:0] CMD     = 4'b0011;
  localparam int         SINGLE  = 2048;
  localparam logic [15:0] SINGLE_FRAME = 16'h3800;
`endif

  logic               clock;
  logic               reset;
  logic               enable;
  logic signed [31:0] PIDout;
  logic               dac_cs_n;
  logic               dac_sclk;
  logic               dac_mosi;
  logic               busy;
  logic               done;
  logic               overrun;
`ifdef DAC_LDAC_EN
  logic               dac_ldac_n;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_ovr  = 0;

  logic [15:0] sh = '0;
  int          nb = 0;
  logic [15:0] frames[$];
  int          fbits[$];
  int          done_cyc[$];

  dac_spi_writer #(.CLK_DIV(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .PIDout   (PIDout),
    .dac_cs_n (dac_cs_n),
    .dac_sclk (dac_sclk),
    .dac_mosi (dac_mosi),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
`ifdef DAC_LDAC_EN
    ,
    .dac_ldac_n (dac_ldac_n)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // DAC-side receiver: sample MOSI on SCLK rise, close the frame on CS rise
  always @(posedge dac_sclk or posedge dac_cs_n) begin
    if (dac_cs_n === 1'b1) begin
      frames.push_back(sh);
      fbits.push_back(nb);
      sh = '0;
      nb = 0;
    end else begin
      sh = {sh[14:0], dac_mosi};
      nb++;
    end
  end

  always @(negedge clock) begin
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (overrun === 1'b1) n_ovr++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic clear_logs();
    frames.delete();
    fbits.delete();
    done_cyc.delete();
  endtask

  task automatic strobe(input int v);
    @(negedge clock);
    enable = 1'b1;
    PIDout = v;
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int t;
    t = 0;
    while (done_cyc.size() < n && t < 2000) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (done_cyc.size() < n) begin
      errors++;
      $display("FAIL %s_wait: done pulses %0d, required %0d", tag, done_cyc.size(), n);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    PIDout = 0;
    #2;
    checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b, required 1", dac_cs_n); end
    checks++; if (dac_sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b, required 0", dac_sclk); end
    checks++; if (dac_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b, required 0", dac_mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b, required 0", overrun); end
`ifdef DAC_LDAC_EN
    checks++; if (dac_ldac_n !== 1'b1) begin errors++; $display("FAIL rst_ldac_n: got %b, required 1", dac_ldac_n); end
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    clear_logs();
  endtask

  task automatic test_single();
    int first_rise, cs_rise, done_k, ldac_first, ldac_low;
    first_rise = -1; cs_rise = -1; done_k = -1; ldac_first = -1; ldac_low = 0;
    clear_logs();
    @(negedge clock);
    enable = 1'b1;
    PIDout = SINGLE;
    @(posedge clock);
    #1 enable = 1'b0;
    for (int k = 1; k <= 1 + 32 * D + HOLD + 4; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_load: got %b, required 1", busy); end
        checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL single_cs_load: got %b, required 1", dac_cs_n); end
      end
      if (k == 2) begin
        checks++; if (dac_cs_n !== 1'b0) begin errors++; $display("FAIL single_cs_low: got %b, required 0", dac_cs_n); end
        checks++; if (dac_mosi !== SINGLE_FRAME[15]) begin errors++; $display("FAIL single_bit15: got %b, required %b", dac_mosi, SINGLE_FRAME[15]); end
      end
      if (first_rise < 0 && dac_sclk === 1'b1) first_rise = k;
      if (cs_rise < 0 && k > 2 && dac_cs_n === 1'b1) cs_rise = k;
      if (done_k < 0 && done === 1'b1) done_k = k;
`ifdef DAC_LDAC_EN
      if (dac_ldac_n === 1'b0) begin
        ldac_low++;
        if (ldac_first < 0) ldac_first = k;
      end
`endif
    end
    checks++; if (first_rise !== 2 + D) begin errors++; $display("FAIL single_first_rise: got %0d, required %0d", first_rise, 2 + D); end
    checks++; if (cs_rise !== 2 + 32 * D) begin errors++; $display("FAIL single_cs_rise: got %0d, required %0d", cs_rise, 2 + 32 * D); end
    checks++; if (done_k !== 1 + 32 * D + HOLD) begin errors++; $display("FAIL single_done_cycle: got %0d, required %0d", done_k, 1 + 32 * D + HOLD); end
    checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL single_done_count: got %0d, required 1", done_cyc.size()); end
    checks++; if (frames.size() !== 1) begin errors++; $display("FAIL single_frame_count: got %0d, required 1", frames.size()); end
    if (frames.size() >= 1) begin
      checks++; if (frames[0] !== SINGLE_FRAME) begin errors++; $display("FAIL single_frame: got %h, required %h", frames[0], SINGLE_FRAME); end
      checks++; if (fbits[0] !== 16) begin errors++; $display("FAIL single_bits: got %0d, required 16", fbits[0]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b, required 0", busy); end
`ifdef DAC_LDAC_EN
    checks++; if (ldac_first !== 2 + 32 * D) begin errors++; $display("FAIL ldac_start: got %0d, required %0d", ldac_first, 2 + 32 * D); end
    checks++; if (ldac_low !== D) begin errors++; $display("FAIL ldac_width: got %0d, required %0d", ldac_low, D); end
`endif
  endtask

  task automatic test_clamp();
    clear_logs();
    strobe(4096);
    wait_done(1, "clamp_hi");
    strobe(-5);
    wait_done(2, "clamp_lo");
    checks++; if (frames.size() !== 2) begin errors++; $display("FAIL clamp_frame_count: got %0d, required 2", frames.size()); end
    if (frames.size() >= 2) begin
      checks++; if (frames[0] !== {CMD, 12'hFFF}) begin errors++; $display("FAIL clamp_high: got %h, required %h", frames[0], {CMD, 12'hFFF}); end
      checks++; if (frames[1] !== {CMD, 12'h000}) begin errors++; $display("FAIL clamp_low: got %h, required %h", frames[1], {CMD, 12'h000}); end
    end
  endtask

  task automatic test_overrun();
    int n0;
    clear_logs();
    n0 = n_ovr;
    strobe(1000);
    repeat (20) @(negedge clock);
    strobe(2000);
    repeat (20) @(negedge clock);
    strobe(3000);
    wait_done(2, "overrun");
    repeat (200) @(negedge clock);
    checks++; if (frames.size() !== 2) begin errors++; $display("FAIL ovr_frame_count: got %0d, required 2", frames.size()); end
    if (frames.size() >= 2) begin
      checks++; if (frames[0] !== {CMD, 12'h3E8}) begin errors++; $display("FAIL ovr_frame0: got %h, required %h", frames[0], {CMD, 12'h3E8}); end
      checks++; if (frames[1] !== {CMD, 12'hBB8}) begin errors++; $display("FAIL ovr_frame1: got %h, required %h", frames[1], {CMD, 12'hBB8}); end
    end
    checks++; if (n_ovr - n0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d, required 1", n_ovr - n0); end
    if (done_cyc.size() >= 2) begin
      checks++; if (done_cyc[1] - done_cyc[0] !== 32 * D + HOLD + 2) begin errors++; $display("FAIL b2b_period: got %0d, required %0d", done_cyc[1] - done_cyc[0], 32 * D + HOLD + 2); end
    end
  endtask

  task automatic test_load_strobe();
    int n0;
    clear_logs();
    n0 = n_ovr;
    @(negedge clock);
    enable = 1'b1;
    PIDout = 500;
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    PIDout = 600;
    @(negedge clock);
    enable = 1'b0;
    wait_done(2, "load_strobe");
    checks++; if (frames.size() !== 2) begin errors++; $display("FAIL load_frame_count: got %0d, required 2", frames.size()); end
    if (frames.size() >= 2) begin
      checks++; if (frames[0] !== {CMD, 12'h1F4}) begin errors++; $display("FAIL load_frame0: got %h, required %h", frames[0], {CMD, 12'h1F4}); end
      checks++; if (frames[1] !== {CMD, 12'h258}) begin errors++; $display("FAIL load_frame1: got %h, required %h", frames[1], {CMD, 12'h258}); end
    end
    checks++; if (n_ovr - n0 !== 0) begin errors++; $display("FAIL load_overrun: got %0d, required 0", n_ovr - n0); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    @(negedge clock);
    enable = 1'b1;
    PIDout = 1234;
    @(posedge clock);
    #1 enable = 1'b0;
    for (int k = 1; k <= 2 + 13 * D; k++) @(posedge clock);
    #1;
    checks++; if (dac_sclk !== 1'b1) begin errors++; $display("FAIL mid_sclk_edge7: got %b, required 1", dac_sclk); end
    reset = 1'b1;
    #1;
    checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n: got %b, required 1", dac_cs_n); end
    checks++; if (dac_sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk: got %b, required 0", dac_sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
    @(negedge clock);
    reset = 1'b0;
    repeat (300) @(negedge clock);
    checks++; if (frames.size() !== 1) begin errors++; $display("FAIL mid_frame_count: got %0d, required 1", frames.size()); end
    if (frames.size() >= 1) begin
      checks++; if (fbits[0] !== 7) begin errors++; $display("FAIL mid_trunc_bits: got %0d, required 7", fbits[0]); end
    end
    checks++; if (done_cyc.size() !== 0) begin errors++; $display("FAIL mid_done_count: got %0d, required 0", done_cyc.size()); end
    checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_after: got %b, required 1", dac_cs_n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clamp();
    test_overrun();
    test_load_strobe();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_writer.md
# dac_spi_writer

Serial DAC transmitter fed by the PID saturator's offset-binary output. It captures one sample per `enable` strobe and clamps it to 12 bits. It then shifts a 16-bit command+data frame MSB-first to an external SPI DAC, so the loop correction reaches the analog actuator. A one-deep pending buffer lets the regulator strobe faster than the serial link: the newest sample always wins.

## Interface
- `CLK_DIV`, 4, clock cycles per SCLK half-period; legal range ≥ 2.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  sample strobe; `PIDout` is valid in the same cycle.
- `PIDout`  in  32 signed  offset-binary DAC code (nominal 0..4096).
- `dac_cs_n`  out  1  DAC chip select, active low.
- `dac_sclk`  out  1  serial clock, idles low; DAC samples on the rising edge.
- `dac_mosi`  out  1  serial data, changes only on SCLK falling edges or at frame start.
- `busy`  out  1  high from LOAD through CS_HOLD.
- `done`  out  1  one-cycle pulse at the end of each frame.
- `overrun`  out  1  one-cycle pulse when `enable` overwrites an unsent pending sample.

## Operation
- Clamp on capture: `PIDout` < 0 → 0; `PIDout` > 4095 → 4095; otherwise `PIDout[11:0]`.
- Capture: an edge with `enable`=1 writes the clamped code to `pend_code` and sets `pend_valid`.
  - If `pend_valid` was already 1 and the state is not LOAD, pulse `overrun`.
- Frame: `{CMD, code[11:0]}`, 16 bits, MSB first.
- FSM states: IDLE, LOAD, SHIFT, CS_HOLD.
  - IDLE: if `pend_valid`, go to LOAD.
  - LOAD (1 cycle): copy the pending code into the shift register and clear `pend_valid`.
    - If `enable` is also asserted that cycle, the new sample is captured and stays pending. No overrun.
    - Drive `dac_cs_n`=0 and `dac_mosi`=bit15.
  - SHIFT: a divider counts `CLK_DIV` cycles per half-period; SCLK toggles.
    - On each falling edge, shift the next bit onto `dac_mosi`.
    - On the 16th falling edge: `dac_cs_n`=1, `dac_mosi`=0, go to CS_HOLD.
  - CS_HOLD: stay `CLK_DIV` cycles with CS high, pulse `done` in the final cycle, then go to IDLE.
- Outputs change only from registers; no combinational path from inputs to pins.

## Timing
- Reset values: `dac_cs_n`=1, `dac_sclk`=0, `dac_mosi`=0, `busy`=0, `done`=0, `overrun`=0, `pend_valid`=0, FSM=IDLE.
- Frame timeline, with capture at edge N:
  - Edge N+1: LOAD.
  - Edge N+2: CS low, bit15 on MOSI.
  - First SCLK rise: N+2+CLK_DIV.
  - Last SCLK fall and CS rise: N+2+32·CLK_DIV.
  - `done` high: cycle after edge N+1+33·CLK_DIV.
- Minimum frame period: 33·CLK_DIV+2 cycles (134 at the default).
- Back-to-back: a sample pending at `done` starts LOAD on the edge after returning to IDLE.
- Reset mid-frame: all outputs go to reset values immediately (async). The pending sample is discarded. The DAC ignores the truncated frame because CS rises before 16 clocks.

## Configuration
- `DAC_LDAC_EN` defined:
  - Adds port `dac_ldac_n` (out, 1, reset 1).
  - CMD = 4'b0000 (write input register).
  - In CS_HOLD, `dac_ldac_n` pulses low for the first `CLK_DIV` cycles, then the block holds a further `CLK_DIV` cycles high before `done`.
  - Frame period becomes 34·CLK_DIV+2.
- Undefined: no `dac_ldac_n`; CMD = 4'b0011 (write-and-update); the DAC updates on CS rise.

## Structure
- Package `dac_pkg`:
  - `FRAME_W`=16, `CODE_W`=12, `CODE_MAX`=4095.
  - `CMD_WRITE_UPDATE`, `CMD_WRITE_INPUT`.
  - FSM state enum.
- Sub-module `dac_sclk_gen`:
  - Divider and SCLK toggle.
  - Emits `rise_tick`/`fall_tick` and a 5-bit edge count.
  - `start` and `clear` inputs.

## Test plan
- `PIDout`=2048, one strobe → MOSI stream 0x3800 sampled on 16 rising SCLK edges; `done` at the cycle given above; CS high otherwise.
- `PIDout`=4096, then −5 → frames 0x3FFF and 0x3000 (clamp both ends).
- Strobe 1000, then 2000 mid-frame, then 3000 mid-frame → frames 0x33E8 and 0x3BB8 only; one `overrun` pulse.
- Strobe in the same cycle as LOAD → no `overrun`; the new code is sent in the next frame.
- Assert `reset` at SCLK edge 7 → CS=1, SCLK=0 within the same cycle; no further frame without a new strobe.
- `DAC_LDAC_EN` build, `PIDout`=100 → frame 0x0064; `dac_ldac_n` low for 4 cycles after CS rise; `done` after.
